lvds_7to1_map_pack: RTL and testbench

LVDS_7TO1_MAP_PACK -- requirements
Module: lvds_7to1_map_pack

---
 rtl/lvds_7to1_map_pack.sv | 223 ++++++++++++++++++++++
 tb/tb_lvds_7to1_map_pack.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_7to1_map_pack.sv
// lvds_7to1_map_pack: maps RGB pixels plus HS/VS/DE onto 7-bit LVDS lane words
// (VESA or JEIDA bit order) and packs odd/even pixel pairs for dual-channel links.
// Optional colour-bar test pattern is compiled in when macro LVDS_TX_TPG_EN is defined.
module lvds_7to1_map_pack #(
   parameter  int NUM_CH     = 2,
   parameter  int COLOR_BITS = 8,
   parameter  int BAR_W      = 64,
   localparam int LANES      = (COLOR_BITS == 8) ? 4 : 3
) (
   input  logic                  I_pix_clk,
   input  logic                  I_rst,
   input  logic                  I_valid,
   input  logic                  I_vs,
   input  logic                  I_hs,
   input  logic                  I_de,
   input  logic [COLOR_BITS-1:0] I_data_r,
   input  logic [COLOR_BITS-1:0] I_data_g,
   input  logic [COLOR_BITS-1:0] I_data_b,
   input  logic                  I_jeida,
`ifdef LVDS_TX_TPG_EN
   input  logic                  I_tpg_on,
`endif
   output logic                  O_valid,
   output logic [LANES*7-1:0]    O_lane_o,
   output logic [LANES*7-1:0]    O_lane_e,
   output logic                  O_pad
);

   typedef enum logic {S_EMPTY, S_HOLD_ODD} pair_state_t;

   // Colour pre-extended to 8 bits so one mapping function serves RGB666 and RGB888.
   function automatic logic [7:0] f_ext(input logic [COLOR_BITS-1:0] c);
      f_ext = 8'(c);
   endfunction

   // Lane words packed as {lane3, lane2, lane1, lane0}; bit 6 of each lane goes out first.
   function automatic logic [27:0] f_map(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic hs,
                                         input logic vs, input logic de, input logic jeida);
      logic [27:0] w_m;
      if (jeida) begin
         w_m[6:0]   = {r[2], r[3], r[4], r[5], r[6], r[7], g[2]};
         w_m[13:7]  = {g[3], g[4], g[5], g[6], g[7], b[2], b[3]};
         w_m[20:14] = {b[4], b[5], b[6], b[7], hs, vs, de};
         w_m[27:21] = {r[0], r[1], g[0], g[1], b[0], b[1], 1'b1};
      end else begin
         w_m[6:0]   = {r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
         w_m[13:7]  = {g[1], g[2], g[3], g[4], g[5], b[0], b[1]};
         w_m[20:14] = {b[2], b[3], b[4], b[5], hs, vs, de};
         w_m[27:21] = {r[6], r[7], g[6], g[7], b[6], b[7], 1'b1};
      end
      f_map = w_m;
   endfunction

   logic [COLOR_BITS-1:0] w_r_in, w_g_in, w_b_in;

`ifdef LVDS_TX_TPG_EN
   localparam int PCW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   // Bar colour as {R,G,B} full-scale enables: W, Y, C, G, M, R, B, K.
   function automatic logic [2:0] f_bar_rgb(input logic [2:0] bar);
      case (bar)
         3'd0:    f_bar_rgb = 3'b111;
         3'd1:    f_bar_rgb = 3'b110;
         3'd2:    f_bar_rgb = 3'b011;
         3'd3:    f_bar_rgb = 3'b010;
         3'd4:    f_bar_rgb = 3'b101;
         3'd5:    f_bar_rgb = 3'b100;
         3'd6:    f_bar_rgb = 3'b001;
         default: f_bar_rgb = 3'b000;
      endcase
   endfunction

   logic [PCW-1:0] r_pix_cnt;
   logic [2:0]     r_bar;
   logic           r_de_prev;
   logic           w_de_rise;
   logic [PCW-1:0] w_pix_cur;
   logic [2:0]     w_bar_cur;
   logic [2:0]     w_bar_rgb;

   // A DE rise restarts the pattern at bar 0 for the pixel that carries it.
   assign w_de_rise = I_de & ~r_de_prev;
   assign w_pix_cur = w_de_rise ? '0 : r_pix_cnt;
   assign w_bar_cur = w_de_rise ? '0 : r_bar;
   assign w_bar_rgb = f_bar_rgb(w_bar_cur);
   assign w_r_in    = I_tpg_on ? {COLOR_BITS{w_bar_rgb[2]}} : I_data_r;
   assign w_g_in    = I_tpg_on ? {COLOR_BITS{w_bar_rgb[1]}} : I_data_g;
   assign w_b_in    = I_tpg_on ? {COLOR_BITS{w_bar_rgb[0]}} : I_data_b;

   // Bar position advances once per valid DE pixel, wrapping after the black bar.
   always_ff @(posedge I_pix_clk or posedge I_rst) begin
      if (I_rst) begin
         r_pix_cnt <= '0;
         r_bar     <= '0;
         r_de_prev <= 1'b0;
      end else if (I_valid) begin
         r_de_prev <= I_de;
         if (I_de) begin
            if (w_pix_cur == PCW'(BAR_W - 1)) begin
               r_pix_cnt <= '0;
               r_bar     <= w_bar_cur + 3'd1;
            end else begin
               r_pix_cnt <= w_pix_cur + PCW'(1);
               r_bar     <= w_bar_cur;
            end
         end
      end
   end
`else
   assign w_r_in = I_data_r;
   assign w_g_in = I_data_g;
   assign w_b_in = I_data_b;
`endif

   logic                  r_v1, r_vs_prev, r_mode;
   logic [COLOR_BITS-1:0] r_r1, r_g1, r_b1;
   logic                  r_hs1, r_vs1, r_de1;

   // Stage 1 control: pixel strobe, VS history and per-frame mapping mode.
   always_ff @(posedge I_pix_clk or posedge I_rst) begin
      if (I_rst) begin
         r_v1      <= 1'b0;
         r_vs_prev <= 1'b0;
         r_mode    <= 1'b0;
      end else begin
         r_v1 <= I_valid;
         if (I_valid) begin
            r_vs_prev <= I_vs;
            if (I_vs && !r_vs_prev) r_mode <= I_jeida;
         end
      end
   end

   // Stage 1 data capture, only on accepted pixels.
   always_ff @(posedge I_pix_clk) begin
      if (I_valid) begin
         r_r1  <= w_r_in;
         r_g1  <= w_g_in;
         r_b1  <= w_b_in;
         r_hs1 <= I_hs;
         r_vs1 <= I_vs;
         r_de1 <= I_de;
      end
   end

   pair_state_t           r_state;
   logic [COLOR_BITS-1:0] r_hr, r_hg, r_hb;
   logic                  r_hhs, r_hvs, r_hde;
   logic                  w_de_chg, w_take, w_emit, w_pad, w_jeida;
   logic [COLOR_BITS-1:0] w_or, w_og, w_ob, w_er, w_eg, w_eb;
   logic                  w_ohs, w_ovs, w_ode;
   logic [27:0]           w_map_o, w_map_e;

   assign w_de_chg = (r_de1 != r_hde);

   // Stage 2 pairing decision: hold an odd pixel, complete a pair, or pad it out.
   always_comb begin
      w_emit = 1'b0;
      w_pad  = 1'b0;
      w_take = 1'b0;
      if (r_v1) begin
         if (NUM_CH == 1) begin
            w_emit = 1'b1;
         end else if (r_state == S_EMPTY) begin
            w_take = 1'b1;
         end else if (w_de_chg) begin
            w_emit = 1'b1;
            w_pad  = 1'b1;
            w_take = 1'b1;
         end else begin
            w_emit = 1'b1;
         end
      end
   end

   assign w_or    = (NUM_CH == 1) ? r_r1  : r_hr;
   assign w_og    = (NUM_CH == 1) ? r_g1  : r_hg;
   assign w_ob    = (NUM_CH == 1) ? r_b1  : r_hb;
   assign w_ohs   = (NUM_CH == 1) ? r_hs1 : r_hhs;
   assign w_ovs   = (NUM_CH == 1) ? r_vs1 : r_hvs;
   assign w_ode   = (NUM_CH == 1) ? r_de1 : r_hde;
   assign w_er    = w_pad ? '0 : r_r1;
   assign w_eg    = w_pad ? '0 : r_g1;
   assign w_eb    = w_pad ? '0 : r_b1;
   assign w_jeida = r_mode && (COLOR_BITS == 8);
   // Both channels carry the odd pixel's sync bits.
   assign w_map_o = f_map(f_ext(w_or), f_ext(w_og), f_ext(w_ob), w_ohs, w_ovs, w_ode, w_jeida);
   assign w_map_e = f_map(f_ext(w_er), f_ext(w_eg), f_ext(w_eb), w_ohs, w_ovs, w_ode, w_jeida);

   // Held odd pixel; replaced whenever the pairing logic takes a new odd.
   always_ff @(posedge I_pix_clk) begin
      if (w_take) begin
         r_hr  <= r_r1;
         r_hg  <= r_g1;
         r_hb  <= r_b1;
         r_hhs <= r_hs1;
         r_hvs <= r_vs1;
         r_hde <= r_de1;
      end
   end

   // Stage 3: pairing state and registered lane outputs; lanes keep the last word between strobes.
   always_ff @(posedge I_pix_clk or posedge I_rst) begin
      if (I_rst) begin
         r_state  <= S_EMPTY;
         O_valid  <= 1'b0;
         O_pad    <= 1'b0;
         O_lane_o <= '0;
         O_lane_e <= '0;
      end else begin
         O_valid <= w_emit;
         if (w_emit) begin
            O_pad    <= w_pad;
            O_lane_o <= w_map_o[LANES*7-1:0];
            O_lane_e <= (NUM_CH == 2) ? w_map_e[LANES*7-1:0] : '0;
         end
         if (r_v1 && (NUM_CH == 2))
            r_state <= (r_state == S_EMPTY || w_de_chg) ? S_HOLD_ODD : S_EMPTY;
      end
   end

endmodule

// File: tb/tb_lvds_7to1_map_pack.sv
// Scoreboard bench for lvds_7to1_map_pack: one dual-channel and one single-channel instance.
module tb_lvds_7to1_map_pack;

   localparam int BW = 2;

   typedef struct packed {
      logic [7:0] r, g, b;
      logic       hs, vs, de;
   } pix_t;

   typedef struct {
      logic [27:0] lo, le;
      logic        pad;
      int          at;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic v1 = 1'b0, v2 = 1'b0;
   logic vs = 1'b0, hs = 1'b0, de = 1'b0, jeida = 1'b0, tpg = 1'b0;
   logic [7:0] dr = '0, dg = '0, db = '0;
   logic o1_valid, o1_pad, o2_valid, o2_pad;
   logic [27:0] o1_lo, o1_le, o2_lo, o2_le;

   int cyc = 0;
   int n_cmp = 0, n_bad = 0;
   exp_t q1[$], q2[$];
   exp_t e1, e2;

   // dual-channel model state
   logic m2_hold = 1'b0, m2_vs_prev = 1'b0, m2_mode = 1'b0, m2_de_prev = 1'b0;
   pix_t m2_h;
   int   m2_bar = 0, m2_pc = 0;
   // single-channel model state
   logic m1_vs_prev = 1'b0, m1_mode = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lvds_7to1_map_pack #(.NUM_CH(2), .COLOR_BITS(8), .BAR_W(BW)) u_dut2 (
      .I_pix_clk(clk), .I_rst(rst), .I_valid(v2), .I_vs(vs), .I_hs(hs), .I_de(de),
      .I_data_r(dr), .I_data_g(dg), .I_data_b(db), .I_jeida(jeida),
`ifdef LVDS_TX_TPG_EN
      .I_tpg_on(tpg),
`endif
      .O_valid(o2_valid), .O_lane_o(o2_lo), .O_lane_e(o2_le), .O_pad(o2_pad));

   lvds_7to1_map_pack #(.NUM_CH(1), .COLOR_BITS(8), .BAR_W(BW)) u_dut1 (
      .I_pix_clk(clk), .I_rst(rst), .I_valid(v1), .I_vs(vs), .I_hs(hs), .I_de(de),
      .I_data_r(dr), .I_data_g(dg), .I_data_b(db), .I_jeida(jeida),
`ifdef LVDS_TX_TPG_EN
      .I_tpg_on(1'b0),
`endif
      .O_valid(o1_valid), .O_lane_o(o1_lo), .O_lane_e(o1_le), .O_pad(o1_pad));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Lane words built bit-by-bit from the mapping tables (JEIDA shifts colour index by 2).
   function automatic logic [27:0] m_map(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic h, input logic v,
                                         input logic d, input logic jd);
      logic [6:0] l0, l1, l2, l3;
      int o;
      o = jd ? 2 : 0;
      for (int k = 0; k < 6; k++) l0[6-k] = r[k+o];
      l0[0] = g[o];
      for (int k = 0; k < 5; k++) l1[6-k] = g[k+1+o];
      l1[1] = b[o];
      l1[0] = b[o+1];
      for (int k = 0; k < 4; k++) l2[6-k] = b[k+2+o];
      l2[2:0] = {h, v, d};
      l3 = jd ? {r[0], r[1], g[0], g[1], b[0], b[1], 1'b1}
              : {r[6], r[7], g[6], g[7], b[6], b[7], 1'b1};
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [23:0] bar_col(input int bar);
      case (bar)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic send2(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic h, input logic v, input logic d, input logic j,
                        input int gap);
      pix_t p;
      exp_t e;
      p.r = r; p.g = g; p.b = b; p.hs = h; p.vs = v; p.de = d;
      if (d && !m2_de_prev) begin m2_bar = 0; m2_pc = 0; end
      if (tpg) {p.r, p.g, p.b} = bar_col(m2_bar);
      if (d) begin
         m2_pc++;
         if (m2_pc == BW) begin m2_pc = 0; m2_bar = (m2_bar + 1) % 8; end
      end
      m2_de_prev = d;
      if (v && !m2_vs_prev) m2_mode = j;
      m2_vs_prev = v;
      e.at  = cyc + 2;
      e.pad = 1'b0;
      if (!m2_hold) begin
         m2_h = p;
         m2_hold = 1'b1;
      end else if (p.de != m2_h.de) begin
         e.lo  = m_map(m2_h.r, m2_h.g, m2_h.b, m2_h.hs, m2_h.vs, m2_h.de, m2_mode);
         e.le  = m_map(8'h00, 8'h00, 8'h00, m2_h.hs, m2_h.vs, m2_h.de, m2_mode);
         e.pad = 1'b1;
         q2.push_back(e);
         m2_h = p;
      end else begin
         e.lo = m_map(m2_h.r, m2_h.g, m2_h.b, m2_h.hs, m2_h.vs, m2_h.de, m2_mode);
         e.le = m_map(p.r, p.g, p.b, m2_h.hs, m2_h.vs, m2_h.de, m2_mode);
         q2.push_back(e);
         m2_hold = 1'b0;
      end
      dr = r; dg = g; db = b; hs = h; vs = v; de = d; jeida = j; v2 = 1'b1;
      @(posedge clk); #1;
      v2 = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic send1(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic h, input logic v, input logic d, input logic j,
                        input logic hand, input logic [27:0] hand_lo);
      exp_t e;
      if (v && !m1_vs_prev) m1_mode = j;
      m1_vs_prev = v;
      e.at  = cyc + 2;
      e.pad = 1'b0;
      e.le  = '0;
      e.lo  = hand ? hand_lo : m_map(r, g, b, h, v, d, m1_mode);
      q1.push_back(e);
      dr = r; dg = g; db = b; hs = h; vs = v; de = d; jeida = j; v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
   endtask

   // Monitor: every output strobe is checked against the oldest expected entry.
   always @(negedge clk) begin
      if (o2_valid) begin
         if (q2.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ch2_unexpected: got O_valid=1 expected no output at %0t", $time);
         end else begin
            e2 = q2.pop_front();
            chk("ch2_lane_o", {4'h0, o2_lo}, {4'h0, e2.lo});
            chk("ch2_lane_e", {4'h0, o2_le}, {4'h0, e2.le});
            chk("ch2_pad", {31'h0, o2_pad}, {31'h0, e2.pad});
            chk("ch2_cycle", cyc, e2.at);
         end
      end
      if (o1_valid) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ch1_unexpected: got O_valid=1 expected no output at %0t", $time);
         end else begin
            e1 = q1.pop_front();
            chk("ch1_lane_o", {4'h0, o1_lo}, {4'h0, e1.lo});
            chk("ch1_lane_e", {4'h0, o1_le}, {4'h0, e1.le});
            chk("ch1_pad", {31'h0, o1_pad}, {31'h0, e1.pad});
            chk("ch1_cycle", cyc, e1.at);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b1;
      #1;
      chk("rst_valid2", {31'h0, o2_valid}, 32'h0);
      chk("rst_pad2", {31'h0, o2_pad}, 32'h0);
      chk("rst_lane_o2", {4'h0, o2_lo}, 32'h0);
      chk("rst_lane_e2", {4'h0, o2_le}, 32'h0);
      chk("rst_lane_o1", {4'h0, o1_lo}, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // single channel: VESA hand vector, then JEIDA hand vector on VS rise
      send1(8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
            {7'b0000001, 7'b0000001, 7'b0000000, 7'b1000000});
      send1(8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
            {7'b1001111, 7'b0000011, 7'b0000000, 7'b0000000});
      send1(8'hFE, 8'h7F, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      send1(8'h5A, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
      send1(8'hC0, 8'hC0, 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      repeat (3) begin @(posedge clk); #1; end

      // dual channel: frame start, 4-pixel line with idle gaps, 3-pixel line then blanking
      send2(8'h11, 8'h22, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      send2(8'h81, 8'h42, 8'h24, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send2(8'hC3, 8'h3C, 8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 2);
      send2(8'h0F, 8'hF0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 3);
      send2(8'hAA, 8'h55, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send2(8'h01, 8'h02, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      send2(8'h10, 8'h20, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send2(8'h77, 8'h88, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send2(8'hE7, 8'h18, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      send2(8'h3F, 8'hFC, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      // JEIDA requested mid-frame: ignored until the next VS rise
      send2(8'h96, 8'h69, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
      send2(8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      send2(8'h9A, 8'hBC, 8'hDE, 1'b1, 1'b1, 1'b0, 1'b1, 0);
      send2(8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send2(8'hF1, 8'hE2, 8'hD3, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      // reset while an odd pixel is held
      send2(8'h5C, 8'hC5, 8'hA3, 1'b0, 1'b1, 1'b1, 1'b0, 3);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'h0, o2_valid}, 32'h0);
      chk("mid_rst_pad", {31'h0, o2_pad}, 32'h0);
      chk("mid_rst_lane_o", {4'h0, o2_lo}, 32'h0);
      chk("mid_rst_lane_e", {4'h0, o2_le}, 32'h0);
      chk("mid_rst_lane_o1", {4'h0, o1_lo}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      m2_hold = 1'b0; m2_vs_prev = 1'b0; m2_mode = 1'b0; m2_de_prev = 1'b0;
      m2_bar = 0; m2_pc = 0; m1_vs_prev = 1'b0; m1_mode = 1'b0;
      send2(8'h21, 8'h43, 8'h65, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      send2(8'h87, 8'hA9, 8'hCB, 1'b0, 1'b1, 1'b1, 1'b0, 1);
`ifdef LVDS_TX_TPG_EN
      // colour bars: blanking pixel then a 16-pixel DE line
      tpg = 1'b1;
      send2(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 16; i++)
         send2(8'h5A, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      tpg = 1'b0;
`endif
      for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk); #1;
      chk("drain_q2", q2.size(), 32'h0);
      chk("drain_q1", q1.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
